// File: rtl/spike_pixel_encoder_if.sv
// rtl/spike_pixel_encoder_if.sv - start/pixel request and spike/strobe response bundle for spike_pixel_encoder
interface spike_pixel_encoder_if #(
    parameter int NUM_PIX = 25,
    parameter int PIX_W   = 8
);
    logic                     start;
    logic [NUM_PIX*PIX_W-1:0] pixel_in;
    logic [NUM_PIX-1:0]       total_pixel;
    logic                     pulse;
    logic                     busy;
    logic                     done;

    modport master (
        output start, pixel_in,
        input  total_pixel, pulse, busy, done
    );

    modport slave (
        input  start, pixel_in,
        output total_pixel, pulse, busy, done
    );
endinterface

// File: rtl/spike_pixel_encoder.sv
// rtl/spike_pixel_encoder.sv - rate-codes latched pixel intensities into per-timestep spike vectors
// ENC_STOCHASTIC_EN selects LFSR comparison encoding instead of the accumulator-carry encoding.
module spike_pixel_encoder #(
    parameter int NUM_PIX   = 25,
    parameter int PIX_W     = 8,
    parameter int NUM_STEPS = 16,
    parameter int STEP_CLKS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    spike_pixel_encoder_if.slave  bus
);
    localparam int CW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam int SW = $clog2(NUM_STEPS + 1);
    localparam int VW = NUM_PIX * PIX_W;
    localparam logic [CW-1:0] CNT_MAX   = CW'(STEP_CLKS - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(NUM_STEPS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [SW-1:0]  step_cnt_q, step_cnt_d;
    logic [VW-1:0]  pix_q, pix_d;
    logic [NUM_PIX-1:0] total_pixel_q, total_pixel_d;
    logic [NUM_PIX-1:0] spike_w;
    logic           pulse_q, pulse_d;

`ifdef ENC_STOCHASTIC_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] lfsr_q, lfsr_d, lfsr_next;

    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    // Each lane compares against its own rotation of the shared LFSR word.
    for (genvar i = 0; i < NUM_PIX; i++) begin : g_lane
        localparam int R = i % 16;
        logic [15:0] rot;
        if (R == 0) begin : g_norot
            assign rot = lfsr_q;
        end else begin : g_rot
            assign rot = {lfsr_q[15-R:0], lfsr_q[15:16-R]};
        end
        assign spike_w[i] = pix_q[i*PIX_W +: PIX_W] > rot[PIX_W-1:0];
    end
`else
    logic [VW-1:0] acc_q, acc_d, acc_next;

    // The carry out of each lane's wrapping accumulator is that lane's spike.
    for (genvar i = 0; i < NUM_PIX; i++) begin : g_lane
        logic [PIX_W:0] sum;
        assign sum = {1'b0, acc_q[i*PIX_W +: PIX_W]} + {1'b0, pix_q[i*PIX_W +: PIX_W]};
        assign acc_next[i*PIX_W +: PIX_W] = sum[PIX_W-1:0];
        assign spike_w[i] = sum[PIX_W];
    end
`endif

    always_comb begin
        state_d       = state_q;
        clk_cnt_d     = clk_cnt_q;
        step_cnt_d    = step_cnt_q;
        pix_d         = pix_q;
        total_pixel_d = total_pixel_q;
        pulse_d       = 1'b0;
`ifdef ENC_STOCHASTIC_EN
        lfsr_d        = lfsr_q;
`else
        acc_d         = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pix_d      = bus.pixel_in;
                    clk_cnt_d  = '0;
                    step_cnt_d = '0;
                    state_d    = S_RUN;
`ifdef ENC_STOCHASTIC_EN
                    lfsr_d     = LFSR_SEED;
`else
                    acc_d      = '0;
`endif
                end
            end
            S_RUN: begin
                if (step_cnt_q == STEP_LAST) begin
                    state_d       = S_DONE;
                    total_pixel_d = '0;
                    clk_cnt_d     = '0;
                end else begin
                    clk_cnt_d = (clk_cnt_q == CNT_MAX) ? '0 : clk_cnt_q + CW'(1);
                    if (clk_cnt_q == CNT_MAX) begin
                        total_pixel_d = spike_w;
                        pulse_d       = 1'b1;
                        step_cnt_d    = step_cnt_q + SW'(1);
`ifdef ENC_STOCHASTIC_EN
                        lfsr_d        = lfsr_next;
`else
                        acc_d         = acc_next;
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            clk_cnt_q     <= '0;
            step_cnt_q    <= '0;
            pix_q         <= '0;
            total_pixel_q <= '0;
            pulse_q       <= 1'b0;
`ifdef ENC_STOCHASTIC_EN
            lfsr_q        <= LFSR_SEED;
`else
            acc_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            clk_cnt_q     <= clk_cnt_d;
            step_cnt_q    <= step_cnt_d;
            pix_q         <= pix_d;
            total_pixel_q <= total_pixel_d;
            pulse_q       <= pulse_d;
`ifdef ENC_STOCHASTIC_EN
            lfsr_q        <= lfsr_d;
`else
            acc_q         <= acc_d;
`endif
        end
    end

    assign bus.total_pixel = total_pixel_q;
    assign bus.pulse       = pulse_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_spike_pixel_encoder.sv
// tb/tb_spike_pixel_encoder.sv - directed scoreboard bench for spike_pixel_encoder
module tb_spike_pixel_encoder;
    localparam int NUM_PIX   = 25;
    localparam int PIX_W     = 8;
    localparam int NUM_STEPS = 16;
    localparam int STEP_CLKS = 4;
    localparam int VW        = NUM_PIX * PIX_W;
    localparam int LAST_C    = NUM_STEPS * STEP_CLKS;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [NUM_PIX-1:0] exp_q[$];
    int                 spike_cnt[NUM_PIX];
    logic [NUM_STEPS-1:0] lane1_mask;

    spike_pixel_encoder_if #(.NUM_PIX(NUM_PIX), .PIX_W(PIX_W)) bus ();

    spike_pixel_encoder #(
        .NUM_PIX(NUM_PIX), .PIX_W(PIX_W), .NUM_STEPS(NUM_STEPS), .STEP_CLKS(STEP_CLKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill_pix(input logic [PIX_W-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < NUM_PIX; i++) r[i*PIX_W +: PIX_W] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_pix();
        logic [VW-1:0] r;
        for (int i = 0; i < NUM_PIX; i++) r[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic push_expected(input logic [VW-1:0] pix);
        logic [NUM_PIX-1:0] v;
`ifdef ENC_STOCHASTIC_EN
        logic [15:0] l;
        logic [15:0] rot;
        int r;
        l = 16'hACE1;
        for (int s = 0; s < NUM_STEPS; s++) begin
            for (int i = 0; i < NUM_PIX; i++) begin
                r = i % 16;
                rot = (l << r) | (l >> (16 - r));
                v[i] = pix[i*PIX_W +: PIX_W] > rot[PIX_W-1:0];
            end
            exp_q.push_back(v);
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
`else
        int acc[NUM_PIX];
        int sum;
        for (int i = 0; i < NUM_PIX; i++) acc[i] = 0;
        for (int s = 0; s < NUM_STEPS; s++) begin
            for (int i = 0; i < NUM_PIX; i++) begin
                sum = acc[i] + int'(pix[i*PIX_W +: PIX_W]);
                v[i] = (sum >= 256);
                acc[i] = sum % 256;
            end
            exp_q.push_back(v);
        end
`endif
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge showing DONE.
    task automatic run_image(input logic [VW-1:0] pix, input bit hold,
                             input int glitch_at, input int abort_at);
        int pulses;
        int step;
        logic [NUM_PIX-1:0] e;
        pulses = 0;
        step = 0;
        lane1_mask = '0;
        for (int i = 0; i < NUM_PIX; i++) spike_cnt[i] = 0;
        exp_q.delete();
        push_expected(pix);
        bus.start = 1'b1;
        bus.pixel_in = pix;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.start = 1'b0;
            bus.pixel_in = ~pix;
        end
        for (int c = 1; c <= LAST_C + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("pulse", 64'(bus.pulse), 64'((c % STEP_CLKS == 0) && (c <= LAST_C)));
            chk("done", 64'(bus.done), 64'(c == LAST_C + 1));
            chk("busy", 64'(bus.busy), 64'(c <= LAST_C));
            if (bus.pulse) begin
                pulses++;
                step++;
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("total_pixel", 64'(bus.total_pixel), 64'(e));
                end
                for (int i = 0; i < NUM_PIX; i++) spike_cnt[i] += int'(bus.total_pixel[i]);
                if (bus.total_pixel[1]) lane1_mask[step-1] = 1'b1;
            end
            if (c == LAST_C + 1) chk("done_clears_total", 64'(bus.total_pixel), 64'd0);
            if (abort_at > 0 && c == abort_at) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("abort_total", 64'(bus.total_pixel), 64'd0);
                chk("abort_pulse", 64'(bus.pulse), 64'd0);
                chk("abort_busy", 64'(bus.busy), 64'd0);
                chk("abort_done", 64'(bus.done), 64'd0);
                reset = 1'b0;
                bus.start = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("abort_no_done", 64'(bus.done), 64'd0);
                    chk("abort_idle_busy", 64'(bus.busy), 64'd0);
                end
                exp_q.delete();
                return;
            end
            if (glitch_at > 0 && c == glitch_at) begin
                bus.start = 1'b1;
                bus.pixel_in = rand_pix();
            end
            if (glitch_at > 0 && c == glitch_at + STEP_CLKS) bus.start = 1'b0;
        end
        chk("pulse_count", 64'(pulses), 64'(NUM_STEPS));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [VW-1:0] p;
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b1;
        bus.pixel_in = fill_pix(8'h80);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_total", 64'(bus.total_pixel), 64'd0);
        chk("rst_pulse", 64'(bus.pulse), 64'd0);
        chk("rst_busy_over_start", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // Half-scale pixels: alternating spike vectors
        run_image(fill_pix(8'h80), 1'b0, 0, 0);
`ifndef ENC_STOCHASTIC_EN
        for (int i = 0; i < NUM_PIX; i++) chk("half_scale_count", 64'(spike_cnt[i]), 64'd8);
`endif
        @(posedge clk);
        @(negedge clk);
        chk("post_done_low", 64'(bus.done), 64'd0);

        // Mixed intensities 0x00 / 0x40 / 0xFF
        p = '0;
        p[1*PIX_W +: PIX_W] = 8'h40;
        p[2*PIX_W +: PIX_W] = 8'hFF;
        run_image(p, 1'b0, 0, 0);
`ifndef ENC_STOCHASTIC_EN
        chk("lane0_count", 64'(spike_cnt[0]), 64'd0);
        chk("lane1_count", 64'(spike_cnt[1]), 64'd4);
        chk("lane2_count", 64'(spike_cnt[2]), 64'd15);
        chk("lane1_steps", 64'(lane1_mask), 64'h8888);
`endif
        @(posedge clk);
        @(negedge clk);

        // start re-asserted with new pixels mid-image
        run_image(rand_pix(), 1'b0, 20, 0);
        @(posedge clk);
        @(negedge clk);

        // reset at step 7, then a full image
        run_image(rand_pix(), 1'b0, 0, 7 * STEP_CLKS);
        run_image(rand_pix(), 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);

        // start held high: DONE plus one IDLE cycle between images
        p = rand_pix();
        run_image(p, 1'b1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_gap_busy", 64'(bus.busy), 64'd0);
        chk("b2b_gap_done", 64'(bus.done), 64'd0);
        chk("b2b_gap_pulse", 64'(bus.pulse), 64'd0);
        run_image(p, 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);

        // All-zero pixels never spike, twice to confirm repeatability
        run_image(fill_pix(8'h00), 1'b0, 0, 0);
        for (int i = 0; i < NUM_PIX; i++) chk("zero_count", 64'(spike_cnt[i]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        run_image(fill_pix(8'h00), 1'b0, 0, 0);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
